// File: rtl/aes_sram_pkg.sv
// Shared types and helpers for the AES-stage SRAM responder.
// Optional alignment checking is controlled by AES_SRAM_ALIGN_CHECK_EN in the top.
package aes_sram_pkg;

  localparam int WORD_BYTES = 16;

  typedef logic [127:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    DUMP,
    INIT
  } state_t;

  // Byte address to word index; the caller range-checks the full result.
  function automatic logic [15:0] addr_to_index(input logic [15:0] addr);
    return addr >> $clog2(WORD_BYTES);
  endfunction

endpackage

// File: rtl/aes_sram_copy_ctr.sv
// Word counter for dump/init copies: restarts at 0 on start, latches the bank,
// and flags the last word so the FSM can return to idle.
module aes_sram_copy_ctr #(
  parameter int WORDS  = 8,
  parameter int IDX_W  = 3,
  parameter int BANK_W = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              en,
  input  logic [BANK_W-1:0] bank_in,
  output logic [IDX_W-1:0]  count,
  output logic [BANK_W-1:0] bank,
  output logic              last
);

  assign last = en && (count == IDX_W'(WORDS - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      count <= '0;
      bank  <= '0;
    end else if (start) begin
      count <= '0;
      bank  <= bank_in;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/aes_sram_resp.sv
// Memory-side responder for the AES-stage SRAM interface: word reads/writes
// plus multi-cycle dump/init copies. Define AES_SRAM_ALIGN_CHECK_EN to reject unaligned accesses.
module aes_sram_resp
  import aes_sram_pkg::*;
#(
  parameter int WORDS    = 8,
  parameter int NUM_SNAP = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         sramRead,
  input  logic         sramWrite,
  input  logic         sramDump,
  input  logic         sramInit,
  input  logic [15:0]  sramAddr,
  input  logic [2:0]   sramDumpNum,
  input  logic [2:0]   sramInitNum,
  input  logic [127:0] sramWriteValue,
  output logic [127:0] sramReadValue,
  output logic         busy,
  output logic         err
);

  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SNAP_W = (NUM_SNAP > 1) ? $clog2(NUM_SNAP) : 1;

  word_t live [WORDS];
  word_t snap [NUM_SNAP][WORDS];

  state_t state, next_state;

  logic [15:0]       idx;
  logic [IDX_W-1:0]  idx_w;
  logic              in_range, aligned, idle;
  logic              dump_bank_ok, init_bank_ok;
  logic              rd_fire, wr_ok, dump_ok, init_ok;
  logic              err_next;
  logic [SNAP_W-1:0] start_bank, copy_bank;
  logic [IDX_W-1:0]  copy_idx;
  logic              copy_last;

  assign idx      = addr_to_index(sramAddr);
  assign idx_w    = idx[IDX_W-1:0];
  assign in_range = idx < 16'(WORDS);
  assign idle     = (state == IDLE);
  assign busy     = !idle;

`ifdef AES_SRAM_ALIGN_CHECK_EN
  assign aligned = (sramAddr[3:0] == 4'd0);
`else
  assign aligned = 1'b1;
`endif

  assign dump_bank_ok = {1'b0, sramDumpNum} < 4'(NUM_SNAP);
  assign init_bank_ok = {1'b0, sramInitNum} < 4'(NUM_SNAP);

  // Out-of-range reads still update the output (to zero); misaligned ones do not.
  assign rd_fire = idle && sramRead && aligned;
  assign wr_ok   = idle && sramWrite && aligned && in_range;
  assign dump_ok = idle && sramDump && dump_bank_ok;
  assign init_ok = idle && sramInit && !sramDump && init_bank_ok;

  assign start_bank = dump_ok ? sramDumpNum[SNAP_W-1:0] : sramInitNum[SNAP_W-1:0];

  assign err_next =
      (busy && (sramRead || sramWrite || sramDump || sramInit)) ||
      (idle && (sramRead || sramWrite) && (!in_range || !aligned)) ||
      (idle && sramDump && !dump_bank_ok) ||
      (idle && sramInit && (sramDump || !init_bank_ok));

  aes_sram_copy_ctr #(
    .WORDS (WORDS),
    .IDX_W (IDX_W),
    .BANK_W(SNAP_W)
  ) u_copy_ctr (
    .clk    (clk),
    .n_rst  (n_rst),
    .start  (dump_ok || init_ok),
    .en     (busy),
    .bank_in(start_bank),
    .count  (copy_idx),
    .bank   (copy_bank),
    .last   (copy_last)
  );

  always_ff @(posedge clk) begin
    if (n_rst) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dump_ok)      next_state = DUMP;
        else if (init_ok) next_state = INIT;
      end
      DUMP, INIT: if (copy_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the arrays are flops rather than an SRAM macro because reset must
  // clear every live and snapshot word.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int w = 0; w < WORDS; w++) begin
        live[w] <= '0;
        for (int b = 0; b < NUM_SNAP; b++) snap[b][w] <= '0;
      end
    end else begin
      if (wr_ok)          live[idx_w] <= sramWriteValue;
      if (state == DUMP)  snap[copy_bank][copy_idx] <= live[copy_idx];
      if (state == INIT)  live[copy_idx] <= snap[copy_bank][copy_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      sramReadValue <= '0;
      err           <= 1'b0;
    end else begin
      err <= err_next;
      if (rd_fire) sramReadValue <= in_range ? live[idx_w] : '0;
    end
  end

endmodule

// File: tb/tb_aes_sram_resp.sv
// Directed self-checking bench for aes_sram_resp (WORDS=8, NUM_SNAP=4).
module tb_aes_sram_resp;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         sramRead, sramWrite, sramDump, sramInit;
  logic [15:0]  sramAddr;
  logic [2:0]   sramDumpNum, sramInitNum;
  logic [127:0] sramWriteValue;
  logic [127:0] sramReadValue;
  logic         busy, err;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] PAT  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] ONES = {128{1'b1}};

  aes_sram_resp #(.WORDS(8), .NUM_SNAP(4)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .sramRead      (sramRead),
    .sramWrite     (sramWrite),
    .sramDump      (sramDump),
    .sramInit      (sramInit),
    .sramAddr      (sramAddr),
    .sramDumpNum   (sramDumpNum),
    .sramInitNum   (sramInitNum),
    .sramWriteValue(sramWriteValue),
    .sramReadValue (sramReadValue),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [127:0] d);
    sramWrite = 1'b1; sramAddr = a; sramWriteValue = d;
    tick();
    sramWrite = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a);
    sramRead = 1'b1; sramAddr = a;
    tick();
    sramRead = 1'b0;
  endtask

  task automatic start_copy(input logic is_dump, input logic [2:0] bank);
    if (is_dump) begin sramDump = 1'b1; sramDumpNum = bank; end
    else         begin sramInit = 1'b1; sramInitNum = bank; end
    tick();
    sramDump = 1'b0; sramInit = 1'b0;
  endtask

  // Counts busy cycles with a bound; a stuck copy shows up as a wrong count.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin n++; tick(); end
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    tick(); tick();
    n_rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (sramReadValue !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", sramReadValue); end
    do_read(16'd32);
    checks++; if (sramReadValue !== '0) begin errors++; $display("FAIL reset_read32: got %h expected 0", sramReadValue); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_read_err: got %b expected 0", err); end
  endtask

  task automatic test_write_read();
    do_write(16'd32, PAT);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", err); end
    do_read(16'd32);
    checks++; if (sramReadValue !== PAT) begin errors++; $display("FAIL wr_rd: got %h expected %h", sramReadValue, PAT); end
    tick(); tick(); tick();
    checks++; if (sramReadValue !== PAT) begin errors++; $display("FAIL rd_hold: got %h expected %h", sramReadValue, PAT); end
  endtask

  task automatic test_read_write_same_cycle();
    do_write(16'd48, 128'h33);
    sramRead = 1'b1; sramWrite = 1'b1; sramAddr = 16'd48; sramWriteValue = 128'h44;
    tick();
    sramRead = 1'b0; sramWrite = 1'b0;
    checks++; if (sramReadValue !== 128'h33) begin errors++; $display("FAIL rw_old: got %h expected 33", sramReadValue); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rw_err: got %b expected 0", err); end
    do_read(16'd48);
    checks++; if (sramReadValue !== 128'h44) begin errors++; $display("FAIL rw_new: got %h expected 44", sramReadValue); end
  endtask

  task automatic test_dump_init();
    int n;
    for (int i = 0; i < 8; i++) do_write(16'(i * 16), 128'(i));
    start_copy(1'b1, 3'd1);
    wait_idle(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL dump_busy_cycles: got %0d expected 8", n); end
    do_write(16'd32, ONES);
    do_read(16'd32);
    checks++; if (sramReadValue !== ONES) begin errors++; $display("FAIL overwrite: got %h expected all-ones", sramReadValue); end
    start_copy(1'b0, 3'd1);
    wait_idle(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL init_busy_cycles: got %0d expected 8", n); end
    do_read(16'd32);
    checks++; if (sramReadValue !== 128'h2) begin errors++; $display("FAIL init_word2: got %h expected 2", sramReadValue); end
    do_read(16'd112);
    checks++; if (sramReadValue !== 128'h7) begin errors++; $display("FAIL init_word7: got %h expected 7", sramReadValue); end
  endtask

  task automatic test_busy_reject();
    int n;
    do_write(16'd0, 128'hA5);
    start_copy(1'b1, 3'd2);
    do_write(16'd0, ONES);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL busy_wr_err: got %b expected 1", err); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL busy_err_pulse: got %b expected 0", err); end
    do_read(16'd16);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL busy_rd_err: got %b expected 1", err); end
    checks++; if (sramReadValue !== 128'h7) begin errors++; $display("FAIL busy_rd_hold: got %h expected 7", sramReadValue); end
    wait_idle(n);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_stuck: got %b expected 0", busy); end
    do_read(16'd0);
    checks++; if (sramReadValue !== 128'hA5) begin errors++; $display("FAIL busy_word0: got %h expected a5", sramReadValue); end
  endtask

  task automatic test_bad_bank();
    int n;
    start_copy(1'b1, 3'd5);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bank5_err: got %b expected 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bank5_busy: got %b expected 0", busy); end
    start_copy(1'b0, 3'd4);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bank4_init: got err=%b busy=%b expected err=1 busy=0", err, busy); end
    // Dump and init together: dump to bank 3 wins, init from bank 1 dropped.
    sramDump = 1'b1; sramDumpNum = 3'd3; sramInit = 1'b1; sramInitNum = 3'd1;
    tick();
    sramDump = 1'b0; sramInit = 1'b0;
    checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL dump_init_both: got err=%b busy=%b expected err=1 busy=1", err, busy); end
    wait_idle(n);
    do_read(16'd0);
    checks++; if (sramReadValue !== 128'hA5) begin errors++; $display("FAIL both_no_init: got %h expected a5", sramReadValue); end
  endtask

  task automatic test_out_of_range();
    do_read(16'd16);
    do_read(16'd128);
    checks++; if (sramReadValue !== '0) begin errors++; $display("FAIL oor_rd: got %h expected 0", sramReadValue); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b expected 1", err); end
    do_write(16'd128, ONES);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b expected 1", err); end
    do_read(16'd0);
    checks++; if (sramReadValue !== 128'hA5) begin errors++; $display("FAIL oor_alias: got %h expected a5", sramReadValue); end
  endtask

  task automatic test_align();
    do_write(16'd33, 128'hBEEF);
`ifdef AES_SRAM_ALIGN_CHECK_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL align_err: got %b expected 1", err); end
    do_read(16'd32);
    checks++; if (sramReadValue !== 128'h2) begin errors++; $display("FAIL align_word2: got %h expected 2", sramReadValue); end
`else
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL align_err: got %b expected 0", err); end
    do_read(16'd32);
    checks++; if (sramReadValue !== 128'hBEEF) begin errors++; $display("FAIL align_word2: got %h expected beef", sramReadValue); end
`endif
  endtask

  task automatic test_reset_mid_copy();
    int n;
    start_copy(1'b1, 3'd0);
    tick(); tick();
    n_rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst: got busy=%b err=%b expected 0 0", busy, err); end
    n_rst = 1'b0;
    do_read(16'd16);
    checks++; if (sramReadValue !== '0) begin errors++; $display("FAIL midrst_live: got %h expected 0", sramReadValue); end
    start_copy(1'b0, 3'd1);
    wait_idle(n);
    do_read(16'd112);
    checks++; if (sramReadValue !== '0) begin errors++; $display("FAIL midrst_snap: got %h expected 0", sramReadValue); end
  endtask

  initial begin
    n_rst = 1'b1;
    sramRead = 1'b0; sramWrite = 1'b0; sramDump = 1'b0; sramInit = 1'b0;
    sramAddr = '0; sramDumpNum = '0; sramInitNum = '0; sramWriteValue = '0;
    test_reset();
    test_write_read();
    test_read_write_same_cycle();
    test_dump_init();
    test_busy_reject();
    test_bad_bank();
    test_out_of_range();
    test_align();
    test_reset_mid_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
